// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        LDR_RX_COUNT,
        LDR_RX_DATA,
        LDR_FLUSH,
        LDR_DONE,
        LDR_ERROR
    } ldr_state_e;

endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// Packs MSB-first serial bytes into 32-bit words; word_valid_o fires
// combinationally with the rx strobe of the final byte.
module uart_boot_loader_word_assembler
    import uart_boot_loader_pkg::*;
(
    input  logic              sysclk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic              partial_o
);

    // Only the leading bytes need storage; the last byte comes straight from rx_data_i.
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [WORD_W-9:0]   shreg_q, shreg_d;
    logic                take;

    assign take = en_i & rx_valid_i;

    always_comb begin
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        if (take) begin
            shreg_d = {shreg_q[WORD_W-17:0], rx_data_i};
            bcnt_d  = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_valid_o = take && (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word_o       = {shreg_q, rx_data_i};
    assign partial_o    = (bcnt_q != '0);

endmodule

// File: rtl/uart_boot_loader.sv
// Boot sequencer: holds the CPU in reset while a length-prefixed word stream
// from the UART is written into data memory, then releases it.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int IDX_W  = $clog2(MAX_WORDS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    ldr_state_e         state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               asm_en;
    logic               word_valid;
    logic [WORD_W-1:0]  word;
    logic               partial;
    logic               idle_sat;
    logic               timeout;

    assign asm_en = (state_q == LDR_RX_COUNT) || (state_q == LDR_RX_DATA);

    uart_boot_loader_word_assembler u_word_assembler (
        .sysclk       (sysclk),
        .rst          (rst),
        .en_i         (asm_en),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word),
        .partial_o    (partial)
    );

    // A strobe in the same cycle always beats the timeout.
    assign idle_sat = (idle_q == IDLE_W'(TIMEOUT_CYCLES));
    assign timeout  = idle_sat && !rx_valid;

    always_comb begin
        idle_d = idle_q;
        if (rx_valid)      idle_d = '0;
        else if (!idle_sat) idle_d = idle_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            LDR_RX_COUNT: begin
                if (word_valid) begin
                    if (word == '0) begin
                        state_d = LDR_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if (word > 32'(MAX_WORDS)) begin
                        state_d = LDR_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LDR_RX_DATA;
                        n_d     = word[IDX_W-1:0];
                        idx_d   = '0;
                    end
                end else if (timeout && partial) begin
                    state_d = LDR_ERROR;
                    err_d   = 1'b1;
                end
            end
            LDR_RX_DATA: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_BASE + 32'({idx_q, 2'b00});
                    wdata_d = word;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == n_q - 1'b1) state_d = LDR_FLUSH;
                end else if (timeout) begin
                    state_d = LDR_ERROR;
                    err_d   = 1'b1;
                end
            end
            LDR_FLUSH: begin
                state_d = LDR_DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q <= LDR_RX_COUNT;
            n_q     <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes are queued as data
// words are sent and checked as mem_we pulses appear.
module tb_uart_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          MAXW = 256;
    localparam int          TO   = 64;

    logic        sysclk = 1'b0;
    logic        rst    = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_count = 0;
    logic [63:0] sb[$];

    always #5 sysclk = ~sysclk;

    uart_boot_loader #(
        .ADDR_BASE      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge sysclk) begin
        logic [63:0] e;
        if (mem_we === 1'b1) begin
            we_count++;
            if (sb.size() == 0) chk("unexp_we", {63'd0, mem_we}, 64'd0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    // Entered and left aligned to a falling edge; consecutive calls give back-to-back strobes.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge sysclk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge sysclk);
        rst = 1'b1;
        we_count = 0;
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    {63'd0, mem_we},     64'd0);
        chk({tag, "_addr"},  {32'd0, mem_addr},   64'd0);
        chk({tag, "_wdata"}, {32'd0, mem_wdata},  64'd0);
        chk({tag, "_hold"},  {63'd0, cpu_hold},   64'd1);
        chk({tag, "_done"},  {63'd0, load_done},  64'd0);
        chk({tag, "_err"},   {63'd0, load_error}, 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        repeat (2) @(negedge sysclk);
        chk_reset_outputs("rst");
        do_reset();

        // Single word with exact release timing
        send_word(32'd1);
        sb.push_back({BASE, 32'hFEDC_BA98});
        send_word(32'hFEDC_BA98);
        chk("t1_done_early", {63'd0, load_done}, 64'd0);
        chk("t1_hold_early", {63'd0, cpu_hold}, 64'd1);
        @(negedge sysclk);
        chk("t1_done", {63'd0, load_done}, 64'd1);
        chk("t1_hold", {63'd0, cpu_hold}, 64'd0);
        chk("t1_we_cnt", 64'(we_count), 64'd1);

        // 20 words back to back, then trailing bytes
        do_reset();
        send_word(32'h14);
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            sb.push_back({BASE + 32'(i * 4), d});
            send_word(d);
        end
        repeat (2) @(negedge sysclk);
        chk("t2_done", {63'd0, load_done}, 64'd1);
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        repeat (3) @(negedge sysclk);
        chk("t2_we_cnt", 64'(we_count), 64'd20);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Zero count
        do_reset();
        send_word(32'd0);
        chk("t3_done", {63'd0, load_done}, 64'd1);
        chk("t3_hold", {63'd0, cpu_hold}, 64'd0);
        repeat (3) @(negedge sysclk);
        chk("t3_we_cnt", 64'(we_count), 64'd0);

        // Oversize count
        do_reset();
        send_word(32'(MAXW + 1));
        chk("t4_err", {63'd0, load_error}, 64'd1);
        chk("t4_hold", {63'd0, cpu_hold}, 64'd1);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        repeat (3) @(negedge sysclk);
        chk("t4_we_cnt", 64'(we_count), 64'd0);
        chk("t4_err_sticky", {63'd0, load_error}, 64'd1);
        chk("t4_done", {63'd0, load_done}, 64'd0);

        // Largest legal count is accepted
        do_reset();
        send_word(32'(MAXW));
        @(negedge sysclk);
        chk("t4b_err", {63'd0, load_error}, 64'd0);

        // Timeout mid data word
        do_reset();
        send_word(32'd2);
        sb.push_back({BASE, 32'hA5A5_0F0F});
        send_word(32'hA5A5_0F0F);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TO - 5) @(negedge sysclk);
        chk("t5_err_early", {63'd0, load_error}, 64'd0);
        repeat (10) @(negedge sysclk);
        chk("t5_err", {63'd0, load_error}, 64'd1);
        chk("t5_hold", {63'd0, cpu_hold}, 64'd1);
        chk("t5_we_cnt", 64'(we_count), 64'd1);

        // Timeout with a partial count word
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (TO + 5) @(negedge sysclk);
        chk("t5b_err", {63'd0, load_error}, 64'd1);

        // Long silence between words in RX_COUNT is harmless
        do_reset();
        repeat (3 * TO) @(negedge sysclk);
        chk("t5c_err", {63'd0, load_error}, 64'd0);
        send_word(32'd1);
        sb.push_back({BASE, 32'h0BAD_CAFE});
        send_word(32'h0BAD_CAFE);
        repeat (2) @(negedge sysclk);
        chk("t5c_done", {63'd0, load_done}, 64'd1);
        chk("t5c_we_cnt", 64'(we_count), 64'd1);

        // Asynchronous reset mid-load, then a fresh load from word 0
        do_reset();
        send_word(32'd5);
        for (int i = 0; i < 3; i++) begin
            d = 32'hC0DE_0000 + 32'(i);
            sb.push_back({BASE + 32'(i * 4), d});
            send_word(d);
        end
        #2 rst = 1'b0;
        #1 chk_reset_outputs("t6_async");
        @(negedge sysclk);
        rst = 1'b1;
        chk("t6_we_cnt", 64'(we_count), 64'd3);
        we_count = 0;
        send_word(32'd1);
        sb.push_back({BASE, 32'h7777_1111});
        send_word(32'h7777_1111);
        repeat (2) @(negedge sysclk);
        chk("t6_done", {63'd0, load_done}, 64'd1);
        chk("t6_we_cnt2", 64'(we_count), 64'd1);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
